// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: ASCII keys, mode indices, FSM states.
package uart_cmd_pkg;

    localparam logic [7:0] KEY_C  = 8'h43;
    localparam logic [7:0] KEY_W  = 8'h57;
    localparam logic [7:0] KEY_T  = 8'h54;
    localparam logic [7:0] KEY_G  = 8'h47;
    localparam logic [7:0] KEY_S  = 8'h53;
    localparam logic [7:0] KEY_M  = 8'h4D;
    localparam logic [7:0] KEY_U  = 8'h55;
    localparam logic [7:0] KEY_D  = 8'h44;
    localparam logic [7:0] KEY_L  = 8'h4C;
    localparam logic [7:0] KEY_R  = 8'h52;
    localparam logic [7:0] KEY_X  = 8'h58;
    localparam logic [7:0] KEY_V  = 8'h56;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_0  = 8'h30;
    localparam logic [7:0] CHR_9  = 8'h39;

    localparam logic [1:0] MODE_IDX_C = 2'd0;
    localparam logic [1:0] MODE_IDX_W = 2'd1;
    localparam logic [1:0] MODE_IDX_T = 2'd2;
    localparam logic [1:0] MODE_IDX_G = 2'd3;

    typedef enum logic [0:0] {IDLE, ARG} state_t;

    // Button bit position -> key: {U,D,L,R} on bits 3..0.
    function automatic logic [7:0] btn_key(input int idx);
        case (idx)
            3:       return KEY_U;
            2:       return KEY_D;
            1:       return KEY_L;
            default: return KEY_R;
        endcase
    endfunction

endpackage

// File: rtl/uart_dec_accum.sv
// Decimal argument accumulator: clear, digit load, digit count and look-ahead overflow flag.
module uart_dec_accum
    import uart_cmd_pkg::*;
#(
    parameter int VAL_W      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [3:0]       digit,
    output logic [VAL_W-1:0] value,
    output logic             has_digits,
    output logic             ovf
);

    localparam int ACC_W = VAL_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_reg;

    // Four spare bits hold acc*10+9 for any in-range acc, so the check sees the untruncated result.
    assign acc_next   = acc_reg * ACC_W'(10) + ACC_W'(digit);
    assign ovf        = (int'(cnt_reg) >= MAX_DIGITS) || (acc_next[ACC_W-1:VAL_W] != '0);
    assign value      = acc_reg[VAL_W-1:0];
    assign has_digits = (cnt_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (load && !ovf) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder for the UART RX FIFO pop side: mode/toggle/pulse keys and V<digits><CR|LF>.
// Optional macro UART_CMD_CASE_FOLD_EN folds lowercase letters to uppercase before decoding.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int  NUM_MODES  = 4,
    parameter int  VAL_W      = 8,
    parameter int  MAX_DIGITS = 3,
    localparam int MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iRx_Valid,
    input  logic [7:0]        iRx_Data,
    output logic [MODE_W-1:0] oMode,
    output logic              oSet,
    output logic              oFnd_Mode,
    output logic [3:0]        oBtn,
    output logic              oTime_En,
    output logic [VAL_W-1:0]  oValue,
    output logic              oValue_Stb,
    output logic              oErr
);

    state_t             state_reg, state_next;
    logic [MODE_W-1:0]  mode_reg, mode_next;
    logic               set_reg, set_next;
    logic               fnd_reg, fnd_next;
    logic [3:0]         btn_reg, btn_next;
    logic               time_en_reg, time_en_next;
    logic [VAL_W-1:0]   value_reg, value_next;
    logic               stb_reg, stb_next;
    logic               err_reg, err_next;

    logic [7:0]         rx_byte;
    logic               is_digit, is_eol;
    logic               mode_hit;
    logic [1:0]         mode_idx;
    logic [3:0]         btn_hit;
    logic               acc_clr, acc_load, acc_has_digits, acc_ovf;
    logic [VAL_W-1:0]   acc_value;

`ifdef UART_CMD_CASE_FOLD_EN
    assign rx_byte = (iRx_Data >= 8'h61 && iRx_Data <= 8'h7A) ? (iRx_Data & 8'hDF) : iRx_Data;
`else
    assign rx_byte = iRx_Data;
`endif

    assign is_digit = (rx_byte >= CHR_0) && (rx_byte <= CHR_9);
    assign is_eol   = (rx_byte == CHR_CR) || (rx_byte == CHR_LF);

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_btn
        assign btn_hit[gi] = (rx_byte == btn_key(gi));
    end

    always_comb begin
        mode_hit = 1'b1;
        mode_idx = MODE_IDX_C;
        case (rx_byte)
            KEY_C:   mode_idx = MODE_IDX_C;
            KEY_W:   mode_idx = MODE_IDX_W;
            KEY_T:   mode_idx = MODE_IDX_T;
            KEY_G:   mode_idx = MODE_IDX_G;
            default: mode_hit = 1'b0;
        endcase
    end

    uart_dec_accum #(
        .VAL_W      (VAL_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_accum (
        .clk        (iClk),
        .rst        (iRst),
        .clr        (acc_clr),
        .load       (acc_load),
        .digit      (rx_byte[3:0]),
        .value      (acc_value),
        .has_digits (acc_has_digits),
        .ovf        (acc_ovf)
    );

    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        set_next     = set_reg;
        fnd_next     = fnd_reg;
        value_next   = value_reg;
        btn_next     = '0;
        time_en_next = 1'b0;
        stb_next     = 1'b0;
        err_next     = 1'b0;
        acc_clr      = 1'b0;
        acc_load     = 1'b0;
        if (iRx_Valid) begin
            case (state_reg)
                IDLE: begin
                    if (rx_byte == KEY_V) begin
                        acc_clr    = 1'b1;
                        state_next = ARG;
                    end else begin
                        if (mode_hit && (int'(mode_idx) < NUM_MODES))
                            mode_next = MODE_W'(mode_idx);
                        if (rx_byte == KEY_S) set_next = ~set_reg;
                        if (rx_byte == KEY_M) fnd_next = ~fnd_reg;
                        btn_next     = btn_hit;
                        time_en_next = (rx_byte == KEY_X);
                    end
                end
                ARG: begin
                    // Every outcome except an accepted digit ends the argument.
                    state_next = IDLE;
                    if (is_digit) begin
                        if (acc_ovf) begin
                            err_next = 1'b1;
                        end else begin
                            acc_load   = 1'b1;
                            state_next = ARG;
                        end
                    end else if (is_eol && acc_has_digits) begin
                        value_next = acc_value;
                        stb_next   = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_reg   <= IDLE;
            mode_reg    <= '0;
            set_reg     <= 1'b0;
            fnd_reg     <= 1'b0;
            btn_reg     <= '0;
            time_en_reg <= 1'b0;
            value_reg   <= '0;
            stb_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            set_reg     <= set_next;
            fnd_reg     <= fnd_next;
            btn_reg     <= btn_next;
            time_en_reg <= time_en_next;
            value_reg   <= value_next;
            stb_reg     <= stb_next;
            err_reg     <= err_next;
        end
    end

    assign oMode      = mode_reg;
    assign oSet       = set_reg;
    assign oFnd_Mode  = fnd_reg;
    assign oBtn       = btn_reg;
    assign oTime_En   = time_en_reg;
    assign oValue     = value_reg;
    assign oValue_Stb = stb_reg;
    assign oErr       = err_reg;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder (NUM_MODES=2, VAL_W=8, MAX_DIGITS=3).
module tb_uart_cmd_decoder;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [0:0] mode;
    logic       set, fnd, time_en, stb, err;
    logic [3:0] btn;
    logic [7:0] value;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .NUM_MODES  (2),
        .VAL_W      (8),
        .MAX_DIGITS (3)
    ) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iRx_Valid  (rx_valid),
        .iRx_Data   (rx_data),
        .oMode      (mode),
        .oSet       (set),
        .oFnd_Mode  (fnd),
        .oBtn       (btn),
        .oTime_En   (time_en),
        .oValue     (value),
        .oValue_Stb (stb),
        .oErr       (err)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic       set;
        logic       fnd;
        logic [3:0] btn;
        logic       ten;
        logic [7:0] value;
        logic       stb;
        logic       err;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic snap_t sample();
        snap_t s;
        s.mode  = {1'b0, mode};
        s.set   = set;
        s.fnd   = fnd;
        s.btn   = btn;
        s.ten   = time_en;
        s.value = value;
        s.stb   = stb;
        s.err   = err;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("mode=%0d set=%0d fnd=%0d btn=%b ten=%0d val=%0d stb=%0d err=%0d",
                         s.mode, s.set, s.fnd, s.btn, s.ten, s.value, s.stb, s.err);
    endfunction

    task automatic expect_out(input string tag, input int m, input int s, input int f,
                              input logic [3:0] b, input int t, input int v,
                              input int sb, input int er);
        snap_t e;
        e.mode  = 2'(m);
        e.set   = 1'(s);
        e.fnd   = 1'(f);
        e.btn   = b;
        e.ten   = 1'(t);
        e.value = 8'(v);
        e.stb   = 1'(sb);
        e.err   = 1'(er);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic tx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic tx_str(input string str);
        for (int i = 0; i < str.len(); i++) tx(str[i]);
    endtask

    task automatic check_reset(input string tag);
        snap_t cur;
        cur = sample();
        n_cmp++;
        if (cur !== '0) begin
            n_bad++;
            $display("FAIL %s got %s required all zero", tag, fmt(cur));
        end else begin
            $display("ok   %s %s", tag, fmt(cur));
        end
    endtask

    // Monitor: any pulse or level change is an output event and must match the next expectation.
    initial begin
        snap_t cur, prev, e;
        string tag;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = sample();
            if (!rst && (cur.btn != 0 || cur.ten || cur.stb || cur.err ||
                         cur.mode != prev.mode || cur.set != prev.set ||
                         cur.fnd != prev.fnd || cur.value != prev.value)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output got %s required no event", fmt(cur));
                end else begin
                    e   = exp_q.pop_front();
                    tag = tag_q.pop_front();
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL %s got %s required %s", tag, fmt(cur), fmt(e));
                    end else begin
                        $display("ok   %s %s", tag, fmt(cur));
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset("reset_values");
        rst = 1'b0;

        // Mode and toggles.
        expect_out("mode_W",   1, 0, 0, 4'b0000, 0, 0, 0, 0); tx("W");
        expect_out("set_on",   1, 1, 0, 4'b0000, 0, 0, 0, 0); tx("S");
        expect_out("fnd_on",   1, 1, 1, 4'b0000, 0, 0, 0, 0); tx("M");
        expect_out("set_off",  1, 0, 1, 4'b0000, 0, 0, 0, 0); tx("S");

        // Back-to-back pulses, including a repeated key.
        expect_out("btn_U1",   1, 0, 1, 4'b1000, 0, 0, 0, 0); tx("U");
        expect_out("btn_U2",   1, 0, 1, 4'b1000, 0, 0, 0, 0); tx("U");
        expect_out("btn_R",    1, 0, 1, 4'b0001, 0, 0, 0, 0); tx("R");
        expect_out("time_X",   1, 0, 1, 4'b0000, 1, 0, 0, 0); tx("X");

        // Arguments.
        tx_str("V125");
        expect_out("val_125",  1, 0, 1, 4'b0000, 0, 125, 1, 0); tx(CR);
        tx("V");
        expect_out("err_empty",1, 0, 1, 4'b0000, 0, 125, 0, 1); tx(LF);
        tx_str("V25");
        expect_out("err_ovf",  1, 0, 1, 4'b0000, 0, 125, 0, 1); tx("6");
        tx(CR);

        // Modes beyond NUM_MODES are silently ignored.
        tx("T");
        tx("G");

        tx_str("V7");
        expect_out("err_badch",1, 0, 1, 4'b0000, 0, 125, 0, 1); tx("Q");
        tx_str("V123");
        expect_out("err_digits",1, 0, 1, 4'b0000, 0, 125, 0, 1); tx("4");
        tx_str("V0");
        expect_out("val_0",    1, 0, 1, 4'b0000, 0, 0, 1, 0); tx(LF);
        tx_str("V255");
        expect_out("val_255",  1, 0, 1, 4'b0000, 0, 255, 1, 0); tx(CR);

        expect_out("mode_C",   0, 0, 1, 4'b0000, 0, 255, 0, 0); tx("C");
        expect_out("btn_D",    0, 0, 1, 4'b0100, 0, 255, 0, 0); tx("D");
        expect_out("btn_L",    0, 0, 1, 4'b0010, 0, 255, 0, 0); tx("L");

        // Lowercase handling.
`ifdef UART_CMD_CASE_FOLD_EN
        expect_out("fold_w",   1, 0, 1, 4'b0000, 0, 255, 0, 0);
        expect_out("fold_x",   1, 0, 1, 4'b0000, 1, 255, 0, 0);
        expect_out("fold_v3",  1, 0, 1, 4'b0000, 0, 3, 1, 0);
`endif
        tx("w");
        tx("x");
        tx_str("v3");
        tx(CR);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of an argument aborts it without error.
        tx_str("V4");
        rst = 1'b1;
        #2;
        check_reset("reset_mid_arg");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx("5");
        tx(CR);
        expect_out("after_rst_M", 0, 0, 1, 4'b0000, 0, 0, 0, 0); tx("M");

        // Drain with a bounded wait; leftovers are missed events.
        repeat (3) @(posedge clk);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
